// File: rtl/ntt_bf_pe_cfg_if.sv
// ntt_bf_pe_cfg_if: butterfly operand/result stream between the memory read ports and write-back.
interface ntt_bf_pe_cfg_if #(
    parameter int DATA_WIDTH = 12
);
    logic                  in_valid;
    logic                  mode;
    logic                  half;
    logic [DATA_WIDTH-1:0] u;
    logic [DATA_WIDTH-1:0] v;
    logic [DATA_WIDTH-1:0] w;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] bf_upper;
    logic [DATA_WIDTH-1:0] bf_lower;

    modport master (
        output in_valid, mode, half, u, v, w,
        input  out_valid, bf_upper, bf_lower
    );

    modport slave (
        input  in_valid, mode, half, u, v, w,
        output out_valid, bf_upper, bf_lower
    );
endinterface

// File: rtl/ntt_bf_pe_cfg.sv
// ntt_bf_pe_cfg: pipelined CT/GS modular butterfly with optional GS halving, fixed latency MUL_LAT+2.
module ntt_bf_pe_cfg #(
    parameter int DATA_WIDTH = 12,
    parameter int Q          = 3329,
    parameter int MUL_LAT    = 3
) (
    input logic            clk,
    input logic            rst,
    ntt_bf_pe_cfg_if.slave bus
);
    localparam int W = DATA_WIDTH;
    localparam logic [W:0]     QX = (W+1)'(Q);
    localparam logic [2*W-1:0] QP = (2*W)'(Q);

    typedef logic [W-1:0] word_t;

    function automatic word_t add_q(word_t a, word_t b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= QX) ? word_t'(s - QX) : word_t'(s);
    endfunction

    function automatic word_t sub_q(word_t a, word_t b);
        return (a < b) ? word_t'({1'b0, a} + QX - {1'b0, b}) : a - b;
    endfunction

    function automatic word_t hlv_q(word_t x);
        logic [W:0] s;
        s = x[0] ? {1'b0, x} + QX : {1'b0, x};
        return word_t'(s >> 1);
    endfunction

    word_t                     u0, v0, w0, a1, b1;
    logic                      m0, h0, vld0;
    logic [MUL_LAT:0][W-1:0]   xd;
    logic [MUL_LAT-1:0][W-1:0] tp;
    logic [MUL_LAT:0]          md, hd, vd;
    logic                      out_v;
    word_t                     up_r, lo_r;
    word_t                     s_add, s_sub, t, x, up_raw, lo_raw, up_n, lo_n;
    logic [2*W-1:0]            prod;

    assign s_add  = add_q(u0, v0);
    assign s_sub  = sub_q(u0, v0);
    assign prod   = {{W{1'b0}}, a1} * {{W{1'b0}}, b1};
    assign t      = tp[MUL_LAT-1];
    assign x      = xd[MUL_LAT];
    // x carries u in CT and the already-formed sum in GS
    assign up_raw = md[MUL_LAT] ? x : add_q(x, t);
    assign lo_raw = md[MUL_LAT] ? t : sub_q(x, t);
    assign up_n   = (md[MUL_LAT] && hd[MUL_LAT]) ? hlv_q(up_raw) : up_raw;
    assign lo_n   = (md[MUL_LAT] && hd[MUL_LAT]) ? hlv_q(lo_raw) : lo_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            u0    <= '0;
            v0    <= '0;
            w0    <= '0;
            m0    <= 1'b0;
            h0    <= 1'b0;
            vld0  <= 1'b0;
            a1    <= '0;
            b1    <= '0;
            xd    <= '0;
            tp    <= '0;
            md    <= '0;
            hd    <= '0;
            vd    <= '0;
            out_v <= 1'b0;
            up_r  <= '0;
            lo_r  <= '0;
        end else begin
            u0    <= bus.u;
            v0    <= bus.v;
            w0    <= bus.w;
            m0    <= bus.mode;
            h0    <= bus.half;
            vld0  <= bus.in_valid;
            a1    <= m0 ? s_sub : v0;
            b1    <= w0;
            xd    <= {xd[MUL_LAT-1:0], (m0 ? s_add : u0)};
            md    <= {md[MUL_LAT-1:0], m0};
            hd    <= {hd[MUL_LAT-1:0], h0};
            vd    <= {vd[MUL_LAT-1:0], vld0};
            tp[0] <= word_t'(prod % QP);
            for (int i = 1; i < MUL_LAT; i++) tp[i] <= tp[i-1];
            out_v <= vd[MUL_LAT];
            if (vd[MUL_LAT]) begin
                up_r <= up_n;
                lo_r <= lo_n;
            end
        end
    end

    assign bus.out_valid = out_v;
    assign bus.bf_upper  = up_r;
    assign bus.bf_lower  = lo_r;
endmodule

// File: tb/tb_ntt_bf_pe_cfg.sv
// tb_ntt_bf_pe_cfg: directed vectors for the butterfly PE at Q=3329, MUL_LAT=3.
module tb_ntt_bf_pe_cfg;
    localparam int DW  = 12;
    localparam int Q   = 3329;
    localparam int ML  = 3;
    localparam int LAT = ML + 2;
    localparam int NV  = 12;

    logic clk = 1'b0;
    logic rst;

    ntt_bf_pe_cfg_if #(.DATA_WIDTH(DW)) bus ();

    ntt_bf_pe_cfg #(.DATA_WIDTH(DW), .Q(Q), .MUL_LAT(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic mode;
        logic half;
        int   u, v, w, up, lo;
    } vec_t;

    vec_t tbl[NV];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_up = 0;
    int   last_lo = 0;
    int   seq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int j);
        if (j < 0) begin
            bus.in_valid = 1'b0;
        end else begin
            bus.in_valid = 1'b1;
            bus.mode     = tbl[j].mode;
            bus.half     = tbl[j].half;
            bus.u        = 12'(tbl[j].u);
            bus.v        = 12'(tbl[j].v);
            bus.w        = 12'(tbl[j].w);
        end
    endtask

    // Plays seq (index into tbl, -1 = bubble) back to back and checks every output cycle.
    task automatic run_stream(input string name);
        int n, j;
        n = seq.size();
        for (int c = 0; c < n + LAT; c++) begin
            drive(c < n ? seq[c] : -1);
            @(posedge clk);
            #1;
            if (c < LAT) begin
                chk({name, "_lead_valid"}, int'(bus.out_valid), 0);
            end else begin
                j = seq[c-LAT];
                if (j < 0) begin
                    chk({name, "_gap_valid"}, int'(bus.out_valid), 0);
                    chk({name, "_gap_upper"}, int'(bus.bf_upper), last_up);
                    chk({name, "_gap_lower"}, int'(bus.bf_lower), last_lo);
                end else begin
                    chk($sformatf("%s_valid[%0d]", name, j), int'(bus.out_valid), 1);
                    chk($sformatf("%s_upper[%0d]", name, j), int'(bus.bf_upper), tbl[j].up);
                    chk($sformatf("%s_lower[%0d]", name, j), int'(bus.bf_lower), tbl[j].lo);
                    last_up = tbl[j].up;
                    last_lo = tbl[j].lo;
                end
            end
        end
        seq.delete();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 100,  2,    17,   134,  66};
        tbl[1]  = '{1'b1, 1'b0, 10,   4,    2,    14,   12};
        tbl[2]  = '{1'b0, 1'b1, 100,  2,    17,   134,  66};
        tbl[3]  = '{1'b1, 1'b1, 10,   4,    2,    7,    6};
        tbl[4]  = '{1'b0, 1'b0, 3000, 1000, 1,    671,  2000};
        tbl[5]  = '{1'b1, 1'b1, 3,    0,    1,    1666, 1666};
        tbl[6]  = '{1'b0, 1'b1, 5,    10,   1,    15,   3324};
        tbl[7]  = '{1'b1, 1'b1, 1,    2,    3,    1666, 1663};
        tbl[8]  = '{1'b0, 1'b0, 0,    3328, 3328, 1,    3328};
        tbl[9]  = '{1'b1, 1'b0, 3328, 3328, 5,    3327, 0};
        tbl[10] = '{1'b0, 1'b0, 1234, 567,  89,   1762, 706};
        tbl[11] = '{1'b1, 1'b1, 17,   3000, 1000, 3173, 3221};

        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.mode = 1'b0;
        bus.half = 1'b0;
        bus.u = '0;
        bus.v = '0;
        bus.w = '0;
        #1;
        chk("reset_valid", int'(bus.out_valid), 0);
        chk("reset_upper", int'(bus.bf_upper), 0);
        chk("reset_lower", int'(bus.bf_lower), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            seq.push_back(i);
            run_stream("single");
        end

        for (int i = 0; i < NV; i++) seq.push_back(i);
        run_stream("stream");

        seq = '{4, -1, 6, 8, -1};
        run_stream("bubble");

        for (int i = 0; i < 3; i++) begin
            drive(i);
            @(posedge clk);
            #1;
        end
        drive(-1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", int'(bus.out_valid), 0);
        chk("midrst_upper", int'(bus.bf_upper), 0);
        chk("midrst_lower", int'(bus.bf_lower), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postrst_valid[%0d]", c), int'(bus.out_valid), 0);
        end
        chk("postrst_upper", int'(bus.bf_upper), 0);
        chk("postrst_lower", int'(bus.bf_lower), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ntt_bf_pe_cfg.md
Name: ntt_bf_pe_cfg

Overview:
- Parametrised, fully pipelined NTT/INTT butterfly processing element; successor to the fixed-mode 12-bit butterfly PE.
- Supports Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT) butterflies, selected per sample, with optional divide-by-2 for INTT scaling.
- Accepts one butterfly per cycle under a valid-only stream handshake with fixed, mode-independent latency.
- Sits between the coefficient memory read ports and the write-back network of the NTT datapath.

Parameters:
- DATA_WIDTH, 12, coefficient and twiddle width in bits.
- Q, 3329, modulus. Must be odd, with 2 < Q < 2^DATA_WIDTH.
- MUL_LAT, 3, pipeline depth of the internal modular multiplier. Must be >= 1.
- Derived LAT = MUL_LAT + 2: total input-to-output latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  u, v, w, mode and half are valid this cycle
- mode  input  1  0 = CT butterfly, 1 = GS butterfly
- half  input  1  1 = halve both results mod Q. Honoured in GS mode only; ignored in CT mode.
- u  input  DATA_WIDTH  upper operand, must be < Q
- v  input  DATA_WIDTH  lower operand, must be < Q
- w  input  DATA_WIDTH  twiddle factor, must be < Q
- out_valid  output  1  bf_upper and bf_lower hold a result
- bf_upper  output  DATA_WIDTH  upper butterfly result
- bf_lower  output  DATA_WIDTH  lower butterfly result

Behaviour:
- Reset: rst low clears immediately (asynchronously) all valid-pipeline bits and all data/output registers to 0, so out_valid=0, bf_upper=0, bf_lower=0.
  - Samples in flight when reset is asserted are discarded and never appear after rst is released.
- Arithmetic (all results in [0, Q-1]):
  - add(a,b) = a+b, minus Q if a+b >= Q; computed at DATA_WIDTH+1 bits.
  - sub(a,b) = a-b, plus Q if a < b.
  - mul(a,b) = (a*b) mod Q; full 2*DATA_WIDTH-bit product, any exact reduction, latency MUL_LAT.
  - hlv(x) = x>>1 if x is even, else (x+Q)>>1; computed at DATA_WIDTH+1 bits.
- CT (mode=0):
  - t = mul(v,w)
  - bf_upper = add(u,t)
  - bf_lower = sub(u,t)
- GS (mode=1):
  - bf_upper = add(u,v)
  - bf_lower = mul(sub(u,v),w)
  - If half=1, both results pass through hlv.
- Pipeline:
  - Stage 0: input registers for u, v, w, mode, half, valid.
  - CT: v*w enters the multiplier in stage 1; u is delayed MUL_LAT cycles to meet it. add, sub and registration happen at the output stage.
  - GS: add/sub are combinational after the input registers. The difference feeds the multiplier; the sum is delayed MUL_LAT cycles. hlv is applied before the output register.
  - Both modes resolve in exactly LAT cycles. Per-sample mode and half travel down the pipeline with the data.
- Timing and ordering:
  - A sample accepted at edge k (in_valid=1) appears with out_valid=1 during the cycle after edge k+LAT.
  - Output order equals input order.
  - Throughput is 1 sample/cycle. There is no backpressure; the consumer must accept every out_valid.
- Mode switching: any mode/half sequence is legal back to back, with no bubbles or stalls required.
- Idle cycles (in_valid=0): produce an out_valid=0 cycle LAT later. bf_upper and bf_lower hold the last valid result (output registers load only when the arriving valid bit is 1).
- Operands >= Q: outputs are unspecified, but out_valid timing is unaffected.

Test Plan:
All scenarios use Q=3329, MUL_LAT=3 (LAT=5).
- CT basic: u=100, v=2, w=17, mode=0 at edge 0 -> out_valid=1 only after edge 5, bf_upper=134, bf_lower=66.
- CT wrap: u=3000, v=1000, w=1 -> bf_upper=671, bf_lower=2000. Next cycle u=5, v=10, w=1 -> bf_lower=3324, bf_upper=15.
- GS with/without half:
  - u=10, v=4, w=2, half=0 -> bf_upper=14, bf_lower=12.
  - Same operands with half=1 -> 7, 6.
  - u=3, v=0, w=1, half=1 -> bf_upper=1666, bf_lower=1666.
  - CT with half=1 (u=100, v=2, w=17) -> 134, 66 (half ignored).
- Back-to-back mixed stream: 8 consecutive samples alternating mode and half -> 8 consecutive out_valid cycles starting 5 cycles later, each matching the reference model in order.
- Bubbles: in_valid pattern 1,0,1,1,0 -> identical out_valid pattern delayed 5 cycles; outputs hold the prior result during gap cycles.
- Reset mid-flight: 3 samples in the pipe, pull rst low between edges -> out_valid, bf_upper and bf_lower go to 0 without waiting for an edge. After release with in_valid=0, out_valid stays 0 for 10+ cycles.
